seg_595_dynamic: RTL and testbench

Six-digit dynamic seven-segment display driver fed by the ROM readout path. It takes the data word selected by the rom_ctrl and key-filter stages, converts it sequentially from binary to BCD, and applies leading-zero blanking, decimal point and sign. It then time-multiplexes the six digits and serializes each digit's select and segment pattern into the board's 74HC595 shift register. It is the last stage before the pins stcp/shcp/ds/oe.

---
 rtl/seg_595_dynamic.sv | 161 ++++++++++++++++
 tb/tb_seg_595_dynamic.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_595_dynamic.sv
// Six-digit multiplexed seven-segment driver: sequential binary-to-BCD, digit
// formatting (blanking, sign, dp), digit scan, and 74HC595 serialization.
module seg_595_dynamic #(
  parameter int CNT_MAX = 49_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [19:0] data,
  input  logic [5:0]  point,
  input  logic        sign,
  input  logic        seg_en,
  output logic        stcp,
  output logic        shcp,
  output logic        ds,
  output logic        oe
);

  localparam int CW = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(CNT_MAX);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

  bcd_state_t  state, state_next;
  logic [4:0]  shift_cnt;
  logic [43:0] dd_reg, dd_adj;
  logic [23:0] bcd_reg;

  logic [CW-1:0] cnt_dwell;
  logic [2:0]    idx, idx_next, hi_digit;
  logic [5:0]    sel_reg, sel_next;
  logic [7:0]    seg_reg, seg_next;
  logic [3:0]    digit_val;

  logic [1:0]  cnt_4;
  logic [3:0]  cnt_bit;
  logic [13:0] frame_reg, frame_live, frame_cur;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'hC0;
      4'd1:    seg_code = 8'hF9;
      4'd2:    seg_code = 8'hA4;
      4'd3:    seg_code = 8'hB0;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h92;
      4'd6:    seg_code = 8'h82;
      4'd7:    seg_code = 8'hF8;
      4'd8:    seg_code = 8'h80;
      4'd9:    seg_code = 8'h90;
      default: seg_code = 8'hFF;
    endcase
  endfunction

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = SHIFT;
      SHIFT:   if (shift_cnt == 5'd19) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Double-dabble step: correct every BCD nibble that would overflow on doubling
  always_comb begin
    dd_adj = dd_reg;
    for (int k = 0; k < 6; k++) begin
      if (dd_reg[20+4*k +: 4] >= 4'd5)
        dd_adj[20+4*k +: 4] = dd_reg[20+4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dd_reg    <= '0;
      shift_cnt <= '0;
      bcd_reg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          dd_reg    <= {24'd0, data};
          shift_cnt <= '0;
        end
        SHIFT: begin
          dd_reg    <= dd_adj << 1;
          shift_cnt <= shift_cnt + 5'd1;
        end
        DONE:    bcd_reg <= dd_reg[43:20];
        default: ;
      endcase
    end
  end

  // Pattern for the digit that becomes active at the next dwell wrap
  always_comb begin
    hi_digit = 3'd0;
    for (int k = 1; k < 6; k++) begin
      if (bcd_reg[4*k +: 4] != 4'd0) hi_digit = 3'(k);
    end
    idx_next  = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    sel_next  = 6'b000001 << idx_next;
    digit_val = bcd_reg[{idx_next, 2'b00} +: 4];
    seg_next  = 8'hFF;
    if (seg_en) begin
      if (idx_next <= hi_digit)
        seg_next = seg_code(digit_val);
      else if (sign && (idx_next == hi_digit + 3'd1))
        seg_next = 8'hBF;
      if (point[idx_next]) seg_next[7] = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_dwell <= '0;
      idx       <= 3'd0;
      sel_reg   <= 6'b000001;
      seg_reg   <= 8'hFF;
    end else if (cnt_dwell == DWELL_LAST) begin
      cnt_dwell <= '0;
      idx       <= idx_next;
      sel_reg   <= sel_next;
      seg_reg   <= seg_next;
    end else begin
      cnt_dwell <= cnt_dwell + CW'(1);
    end
  end

  // Bit 0 is taken live so the frame snapshot and its first bit coincide
  assign frame_live = {seg_reg, sel_reg};
  assign frame_cur  = (cnt_bit == 4'd0) ? frame_live : frame_reg;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_4     <= 2'd0;
      cnt_bit   <= 4'd0;
      frame_reg <= {8'hFF, 6'b000001};
      ds        <= 1'b0;
      shcp      <= 1'b0;
      stcp      <= 1'b0;
      oe        <= 1'b1;
    end else begin
      cnt_4 <= cnt_4 + 2'd1;
      if (cnt_4 == 2'd3)
        cnt_bit <= (cnt_bit == 4'd13) ? 4'd0 : cnt_bit + 4'd1;
      if (cnt_bit == 4'd0 && cnt_4 == 2'd0)
        frame_reg <= frame_live;
      if (cnt_4 == 2'd0)
        ds <= frame_cur[cnt_bit];
      shcp <= cnt_4[1];
      stcp <= (cnt_bit == 4'd13) && (cnt_4 == 2'd3);
      oe   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_595_dynamic.sv
// Randomized self-checking bench for seg_595_dynamic: decodes the 595 serial
// stream into frames and compares them with a digit-level reference model.
module tb_seg_595_dynamic;

  localparam int CNT_MAX = 99;
  localparam logic [7:0] SEG_CODE [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [19:0] data = '0;
  logic [5:0]  point = '0;
  logic        sign = 1'b0;
  logic        seg_en = 1'b1;
  logic        stcp, shcp, ds, oe;

  int n_cmp = 0;
  int n_bad = 0;

  logic [13:0] fq[$];

  seg_595_dynamic #(.CNT_MAX(CNT_MAX)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .data(data), .point(point),
    .sign(sign), .seg_en(seg_en), .stcp(stcp), .shcp(shcp), .ds(ds), .oe(oe)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits by arithmetic, then blanking/sign/dp rules
  function automatic logic [7:0] exp_seg(input int unsigned val, input logic [5:0] pt,
                                         input logic sg, input logic en, input int i);
    int unsigned v;
    int dig[6];
    int h;
    logic [7:0] s;
    v = val % 1000000;
    h = 0;
    for (int k = 0; k < 6; k++) begin
      dig[k] = int'(v % 10);
      v = v / 10;
      if (dig[k] != 0) h = k;
    end
    if (!en) return 8'hFF;
    if (i <= h)                 s = SEG_CODE[dig[i]];
    else if (sg && i == h + 1)  s = 8'hBF;
    else                        s = 8'hFF;
    if (pt[i]) s[7] = 1'b0;
    return s;
  endfunction

  // Frame decoder: a bit per shcp rise, a frame per stcp pulse
  logic        shcp_q;
  int          nbits, gap;
  bit          first;
  logic [13:0] bits;
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      shcp_q = 1'b0; nbits = 0; gap = 0; first = 1'b1;
    end else begin
      gap++;
      if (shcp && !shcp_q) begin
        if (nbits < 14) bits[nbits] = ds;
        nbits++;
      end
      if (stcp) begin
        checkOutput("shcp_per_frame", nbits, 14);
        if (!first) checkOutput("stcp_spacing", gap, 56);
        if (nbits == 14) fq.push_back(bits);
        nbits = 0; gap = 0; first = 1'b0;
      end
      shcp_q = shcp;
    end
  end

  task automatic applyStimulus(input logic [19:0] d, input logic [5:0] p,
                               input logic s, input logic e);
    @(negedge sys_clk);
    data = d; point = p; sign = s; seg_en = e;
  endtask

  task automatic wait_frame(output logic [13:0] f, output bit ok);
    int t = 0;
    while (fq.size() == 0 && t < 200) begin
      @(negedge sys_clk);
      t++;
    end
    ok = (fq.size() != 0);
    if (!ok) begin
      checkOutput("frame_timeout", 0, 1);
      f = '0;
    end else begin
      f = fq.pop_front();
    end
  endtask

  task automatic wait_stcp();
    int t = 0;
    while (!stcp && t < 200) begin
      @(negedge sys_clk);
      t++;
    end
    if (!stcp) checkOutput("stcp_timeout", 0, 1);
  endtask

  function automatic int sel_index(input logic [5:0] sel);
    for (int k = 0; k < 6; k++) if (sel[k]) return k;
    return 0;
  endfunction

  task automatic check_frames(input int n);
    logic [13:0] f;
    logic [5:0]  prev, mask;
    bit ok, have_prev;
    int i;
    mask = '0;
    have_prev = 1'b0;
    prev = '0;
    for (int k = 0; k < n; k++) begin
      wait_frame(f, ok);
      if (!ok) return;
      checkOutput("sel_onehot", 32'($onehot(f[5:0])), 1);
      i = sel_index(f[5:0]);
      checkOutput($sformatf("seg_d%0d", i), f[13:6],
                  exp_seg(data, point, sign, seg_en, i));
      if (have_prev)
        checkOutput("scan_order", 32'(f[5:0] == prev || f[5:0] == {prev[4:0], prev[5]}), 1);
      prev = f[5:0];
      have_prev = 1'b1;
      mask |= f[5:0];
    end
    checkOutput("digits_seen", mask, 6'h3F);
  endtask

  task automatic run_vector(input logic [19:0] d, input logic [5:0] p,
                            input logic s, input logic e);
    applyStimulus(d, p, s, e);
    repeat (300) @(negedge sys_clk);
    fq.delete();
    check_frames(14);
  endtask

  initial begin
    logic [13:0] f;
    bit ok;
    logic [19:0] rd;

    #200;
    checkOutput("rst_stcp", stcp, 0);
    checkOutput("rst_shcp", shcp, 0);
    checkOutput("rst_ds", ds, 0);
    checkOutput("rst_oe", oe, 1);
    @(negedge sys_clk);
    data = 20'd123456; point = '0; sign = 1'b0; seg_en = 1'b1;
    sys_rst_n = 1'b1;
    #1 checkOutput("oe_before_edge", oe, 1);
    @(posedge sys_clk);
    #1 checkOutput("oe_after_release", oe, 0);
    wait_frame(f, ok);
    if (ok) checkOutput("first_frame", f, {8'hFF, 6'b000001});

    $display("[TB] directed patterns");
    run_vector(20'd123456, 6'b000000, 1'b0, 1'b1);
    run_vector(20'd42,     6'b000010, 1'b1, 1'b1);
    run_vector(20'd0,      6'b000000, 1'b0, 1'b1);
    run_vector(20'd999999, 6'b000000, 1'b1, 1'b1);
    run_vector(20'd0,      6'b101010, 1'b1, 1'b1);
    run_vector(20'd1048575, 6'b000001, 1'b1, 1'b1);

    $display("[TB] randomized patterns");
    for (int k = 0; k < 6; k++) begin
      rd = (k % 2 == 0) ? 20'($urandom_range(0, 20'hFFFFF)) : 20'($urandom_range(0, 9999));
      run_vector(rd, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("[TB] seg_en drop mid-frame");
    applyStimulus(20'd70513, 6'b000100, 1'b1, 1'b1);
    repeat (300) @(negedge sys_clk);
    wait_stcp();
    repeat (20) @(negedge sys_clk);
    seg_en = 1'b0;
    fq.delete();
    wait_frame(f, ok);
    if (ok)
      checkOutput("inflight_frame", f[13:6],
                  exp_seg(data, point, sign, 1'b1, sel_index(f[5:0])));
    repeat (300) @(negedge sys_clk);
    fq.delete();
    check_frames(14);

    $display("[TB] reset mid-frame");
    applyStimulus(20'd8675, 6'b000000, 1'b0, 1'b1);
    repeat (300) @(negedge sys_clk);
    wait_stcp();
    repeat (25) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    checkOutput("midrst_stcp", stcp, 0);
    checkOutput("midrst_shcp", shcp, 0);
    checkOutput("midrst_ds", ds, 0);
    checkOutput("midrst_oe", oe, 1);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    fq.delete();
    wait_frame(f, ok);
    if (ok) checkOutput("post_reset_frame", f, {8'hFF, 6'b000001});
    run_vector(20'd8675, 6'b000000, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
